// File: rtl/mole_sequencer_if.sv
// Player-facing signal bundle for the whack-a-mole sequencer.
// The master side drives buttons and start; the slave side drives the mole lights and counters.
interface mole_sequencer_if #(
  parameter int N_MOLES = 9
);
  logic               start;
  logic [1:0]         level;
  logic [N_MOLES-1:0] hit;
  logic [N_MOLES-1:0] mole;
  logic [7:0]         score;
  logic [7:0]         misses;
  logic               done;

  modport master (output start, level, hit, input mole, score, misses, done);
  modport slave  (input start, level, hit, output mole, score, misses, done);
endinterface

// File: rtl/mole_sequencer.sv
// Whack-a-mole game sequencer: pseudo-random mole selection, timed gap/up phases, score and miss tracking.
// Optional macro WAM_PENALTY_EN: a rise on an unlit button while a mole is up takes a point off the score.
module mole_sequencer #(
  parameter int N_MOLES     = 9,
  parameter int BASE_CYCLES = 12_500_000,
  parameter int MAX_MISSES  = 8
) (
  input logic             CLOCK_50,
  input logic             reset,
  mole_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GAP, UP, OVER} state_t;

  localparam logic [27:0] GAP_L0 = 28'(8 * BASE_CYCLES - 1);
  localparam logic [27:0] GAP_L1 = 28'(4 * BASE_CYCLES - 1);
  localparam logic [27:0] GAP_L2 = 28'(2 * BASE_CYCLES - 1);
  localparam logic [27:0] GAP_L3 = 28'(1 * BASE_CYCLES - 1);
  localparam logic [27:0] UP_L0  = 28'(8 * BASE_CYCLES - 1);
  localparam logic [27:0] UP_L1  = 28'(4 * BASE_CYCLES - 1);
  localparam logic [27:0] UP_L2  = 28'(4 * BASE_CYCLES - 1);
  localparam logic [27:0] UP_L3  = 28'(2 * BASE_CYCLES - 1);

  state_t             state_reg, state_next;
  logic [27:0]        cnt_reg, cnt_next;
  logic [N_MOLES-1:0] mole_reg, mole_next;
  logic [7:0]         score_reg, score_next;
  logic [7:0]         misses_reg, misses_next;
  logic [1:0]         level_reg, level_next;
  logic [3:0]         prev_idx_reg, prev_idx_next;
  logic               prev_valid_reg, prev_valid_next;
  logic [N_MOLES-1:0] hit_q_reg;
  logic [15:0]        lfsr_reg;

  logic [N_MOLES-1:0] rise;
  logic               correct_rise;
  logic [3:0]         raw_idx;
  logic [3:0]         sel_idx;
  logic [N_MOLES-1:0] sel_onehot;
  logic [7:0]         misses_inc;

  function automatic logic [27:0] gap_load(input logic [1:0] lv);
    case (lv)
      2'd0:    return GAP_L0;
      2'd1:    return GAP_L1;
      2'd2:    return GAP_L2;
      default: return GAP_L3;
    endcase
  endfunction

  function automatic logic [27:0] up_load(input logic [1:0] lv);
    case (lv)
      2'd0:    return UP_L0;
      2'd1:    return UP_L1;
      2'd2:    return UP_L2;
      default: return UP_L3;
    endcase
  endfunction

  assign rise         = bus.hit & ~hit_q_reg;
  assign correct_rise = |(rise & mole_reg);

  // Scale the low LFSR byte into 0..N_MOLES-1, then step past a repeat of the last lit mole.
  assign raw_idx = 4'((12'(lfsr_reg[7:0]) * 12'(N_MOLES)) >> 8);
  assign sel_idx = (prev_valid_reg && (raw_idx == prev_idx_reg))
                 ? ((raw_idx == 4'(N_MOLES - 1)) ? 4'd0 : raw_idx + 4'd1)
                 : raw_idx;

  generate
    for (genvar gi = 0; gi < N_MOLES; gi++) begin : g_decode
      assign sel_onehot[gi] = (sel_idx == 4'(gi));
    end
  endgenerate

  assign misses_inc = (misses_reg == 8'hFF) ? 8'hFF : misses_reg + 8'd1;

`ifdef WAM_PENALTY_EN
  logic wrong_rise;
  assign wrong_rise = |(rise & ~mole_reg);
`endif

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    mole_next       = mole_reg;
    score_next      = score_reg;
    misses_next     = misses_reg;
    level_next      = level_reg;
    prev_idx_next   = prev_idx_reg;
    prev_valid_next = prev_valid_reg;

    case (state_reg)
      IDLE, OVER: begin
        if (bus.start) begin
          state_next  = GAP;
          score_next  = 8'd0;
          misses_next = 8'd0;
          level_next  = bus.level;
          cnt_next    = gap_load(bus.level);
          mole_next   = '0;
        end
      end
      GAP: begin
        if (cnt_reg == 28'd0) begin
          state_next      = UP;
          mole_next       = sel_onehot;
          cnt_next        = up_load(level_reg);
          prev_idx_next   = sel_idx;
          prev_valid_next = 1'b1;
        end else begin
          cnt_next = cnt_reg - 28'd1;
        end
      end
      UP: begin
`ifdef WAM_PENALTY_EN
        if (!correct_rise && wrong_rise && (score_reg != 8'd0))
          score_next = score_reg - 8'd1;
`endif
        // A correct whack wins over a simultaneous timeout.
        if (correct_rise) begin
          score_next = (score_reg == 8'hFF) ? 8'hFF : score_reg + 8'd1;
          mole_next  = '0;
          state_next = GAP;
          cnt_next   = gap_load(level_reg);
        end else if (cnt_reg == 28'd0) begin
          misses_next = misses_inc;
          mole_next   = '0;
          if (misses_inc == 8'(MAX_MISSES)) begin
            state_next = OVER;
            cnt_next   = 28'd0;
          end else begin
            state_next = GAP;
            cnt_next   = gap_load(level_reg);
          end
        end else begin
          cnt_next = cnt_reg - 28'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= 28'd0;
      mole_reg       <= '0;
      score_reg      <= 8'd0;
      misses_reg     <= 8'd0;
      level_reg      <= 2'd0;
      prev_idx_reg   <= 4'd0;
      prev_valid_reg <= 1'b0;
      hit_q_reg      <= '0;
      lfsr_reg       <= 16'hACE1;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      mole_reg       <= mole_next;
      score_reg      <= score_next;
      misses_reg     <= misses_next;
      level_reg      <= level_next;
      prev_idx_reg   <= prev_idx_next;
      prev_valid_reg <= prev_valid_next;
      hit_q_reg      <= bus.hit;
      lfsr_reg       <= {lfsr_reg[14:0],
                         lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
    end
  end

  assign bus.mole   = mole_reg;
  assign bus.score  = score_reg;
  assign bus.misses = misses_reg;
  assign bus.done   = (state_reg == OVER);

endmodule
